// File: rtl/fetch_instr_buffer_pkg.sv
// Shared types and widths for the fetch-to-decode instruction queue.
package fetch_instr_buffer_pkg;
  localparam int XLEN    = 32;
  localparam int FETCH_W = 5;
  localparam int DEC_W   = 3;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Out-of-range slot counts collapse to zero pushes.
  function automatic logic [2:0] legal_count(input logic [2:0] c);
    return (c >= 3'd1 && c <= 3'(FETCH_W)) ? c : 3'd0;
  endfunction
endpackage

// File: rtl/fetch_instr_buffer_if.sv
// Fetch-group input and decode-window output bundle for fetch_instr_buffer.
interface fetch_instr_buffer_if import fetch_instr_buffer_pkg::*; #(parameter int DEPTH = 16);
  logic                      flush_i;
  logic                      secure_mode_i;
  logic                      fetch_valid_i;
  logic [2:0]                fetch_count_i;
  logic [FETCH_W*XLEN-1:0]   fetch_inst_i;
  logic [FETCH_W*XLEN-1:0]   fetch_pc_i;
  logic                      buble_o;
  logic [DEC_W-1:0]          dec_valid_o;
  logic [DEC_W*XLEN-1:0]     dec_inst_o;
  logic [DEC_W*XLEN-1:0]     dec_pc_o;
  logic [1:0]                dec_accept_i;
  logic [$clog2(DEPTH):0]    occupancy_o;

  modport master (
    output flush_i, secure_mode_i, fetch_valid_i, fetch_count_i, fetch_inst_i, fetch_pc_i,
           dec_accept_i,
    input  buble_o, dec_valid_o, dec_inst_o, dec_pc_o, occupancy_o
  );

  modport slave (
    input  flush_i, secure_mode_i, fetch_valid_i, fetch_count_i, fetch_inst_i, fetch_pc_i,
           dec_accept_i,
    output buble_o, dec_valid_o, dec_inst_o, dec_pc_o, occupancy_o
  );
endinterface

// File: rtl/fetch_instr_buffer_ptr_ctrl.sv
// Head/tail/count bookkeeping, push gating, stall and decode-valid generation.
module fb_ptr_ctrl import fetch_instr_buffer_pkg::*; #(
  parameter  int DEPTH = 16,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             secure_mode,
  input  logic             fetch_valid,
  input  logic [2:0]       fetch_count,
  input  logic [1:0]       dec_accept,
  output logic [PW-1:0]    head,
  output logic [PW-1:0]    tail,
  output logic [CW-1:0]    count,
  output logic             push,
  output logic [2:0]       n_push,
  output logic             buble,
  output logic [DEC_W-1:0] dec_valid
);

  logic [2:0] n_in;

  // Stall looks only at registered count, so same-cycle pops never relax it.
  always_comb begin
    n_push = secure_mode ? 3'd1 : legal_count(fetch_count);
    buble  = (count > CW'(DEPTH - FETCH_W)) & ~flush;
    push   = fetch_valid & ~buble & ~flush;
    n_in   = push ? n_push : '0;
    for (int unsigned j = 0; j < DEC_W; j++) begin
      dec_valid[j] = (count > CW'(j));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(dec_accept);
      tail  <= tail + PW'(n_in);
      count <= count + CW'(n_in) - CW'(dec_accept);
    end
  end

  a_fetch_count_legal: assert property (@(posedge clk) disable iff (!reset)
    (fetch_valid && !secure_mode && !flush) |-> (fetch_count >= 3'd1 && fetch_count <= 3'(FETCH_W)));

  a_accept_le_valid: assert property (@(posedge clk) disable iff (!reset)
    !flush |-> (CW'(dec_accept) <= count));

  a_count_bound: assert property (@(posedge clk) disable iff (!reset)
    count <= CW'(DEPTH));

  a_secure_toggle_empty: assert property (@(posedge clk) disable iff (!reset)
    (secure_mode != $past(secure_mode)) |-> (count == '0));

endmodule

// File: rtl/fetch_instr_buffer.sv
// Instruction queue between the 5-wide fetch stage and the 3-wide decode stage.
module fetch_instr_buffer import fetch_instr_buffer_pkg::*; #(
  parameter int DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_instr_buffer_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t          mem [DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [PW:0]           count;
  logic                  push;
  logic [2:0]            n_push;
  logic                  buble;
  logic [DEC_W-1:0]      dec_valid;
  logic [DEC_W*XLEN-1:0] dec_inst;
  logic [DEC_W*XLEN-1:0] dec_pc;
  fetch_entry_t          rd;

  fb_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
    .clk         (clk),
    .reset       (reset),
    .flush       (bus.flush_i),
    .secure_mode (bus.secure_mode_i),
    .fetch_valid (bus.fetch_valid_i),
    .fetch_count (bus.fetch_count_i),
    .dec_accept  (bus.dec_accept_i),
    .head        (head),
    .tail        (tail),
    .count       (count),
    .push        (push),
    .n_push      (n_push),
    .buble       (buble),
    .dec_valid   (dec_valid)
  );

  // One write port per fetch slot; slot k lands at tail+k.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      for (int unsigned k = 0; k < FETCH_W; k++) begin
        if (3'(k) < n_push) begin
          mem[tail + PW'(k)] <= '{pc:   bus.fetch_pc_i[k*XLEN +: XLEN],
                                  inst: bus.fetch_inst_i[k*XLEN +: XLEN]};
        end
      end
    end
  end

  always_comb begin
    dec_inst = '0;
    dec_pc   = '0;
    rd       = '0;
    for (int unsigned j = 0; j < DEC_W; j++) begin
      rd = mem[head + PW'(j)];
      if (dec_valid[j]) begin
        dec_inst[j*XLEN +: XLEN] = rd.inst;
        dec_pc[j*XLEN +: XLEN]   = rd.pc;
      end
    end
  end

  assign bus.buble_o     = buble;
  assign bus.dec_valid_o = dec_valid;
  assign bus.dec_inst_o  = dec_inst;
  assign bus.dec_pc_o    = dec_pc;
  assign bus.occupancy_o = count;

endmodule
